// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing for the restoring divider
package div_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
endpackage

// File: rtl/div_restoring.sv
// div_restoring: sequential signed restoring divider, quotient on lo, remainder on hi
module div_restoring
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);
    div_state_t       state;
    logic [WIDTH-1:0] rem, quo, dsr;
    logic [CW-1:0]    cnt;
    logic             neg_a, neg_b, zero_pend;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    // Extra guard bit: with |divisor| up to 2^(WIDTH-1)... 2^WIDTH the shifted remainder needs WIDTH+1 bits.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b0, dsr};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rem       <= '0;
            quo       <= '0;
            dsr       <= '0;
            cnt       <= '0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            zero_pend <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy      <= 1'b1;
                    zero_pend <= divisor == '0;
                    state     <= divisor == '0 ? DONE : CALC;
                    neg_a     <= dividend[WIDTH-1];
                    neg_b     <= divisor[WIDTH-1];
                    quo       <= dividend[WIDTH-1] ? -dividend : dividend;
                    dsr       <= divisor[WIDTH-1] ? -divisor : divisor;
                    rem       <= '0;
                    cnt       <= CW'(WIDTH - 1);
                end
                CALC: begin
                    rem <= trial[WIDTH+1] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH+1]};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= FIX;
                end
                FIX: begin
                    lo    <= (neg_a ^ neg_b) ? -quo : quo;
                    hi    <= neg_a ? -rem : rem;
                    state <= DONE;
                end
                default: begin
                    done     <= 1'b1;
                    div_zero <= zero_pend;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_restoring.sv
// tb_div_restoring: randomized self-checking bench against a longint arithmetic model
module tb_div_restoring;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;
    int          vectors = 0;
    int          errors = 0;

    div_restoring dut (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int repulse,
                          output logic [31:0] q, output logic [31:0] r, output logic dz,
                          output int lat, output int bcyc, output logic wide);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat = -1; bcyc = int'(busy); wide = 1'b0; q = '0; r = '0; dz = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (n == repulse) begin
                start = 1'b1; dividend = 32'd77; divisor = 32'd5;
            end else
                start = 1'b0;
            @(posedge clk); #1;
            if (done) begin
                lat = n; q = lo; r = hi; dz = div_zero;
                @(posedge clk); #1;
                wide = done;
                break;
            end
            bcyc += int'(busy);
        end
        start = 1'b0;
    endtask

    task automatic check_div(input string name, input logic [31:0] a, input logic [31:0] b, input int repulse);
        logic [31:0] q, r;
        logic        dz, wide;
        int          lat, bcyc;
        logic [63:0] exp;
        exp = model(a, b);
        do_div(a, b, repulse, q, r, dz, lat, bcyc, wide);
        vectors++;
        if ({r, q} !== exp) begin
            errors++;
            $display("FAIL %s result %h/%h: hi=%h lo=%h want hi=%h lo=%h", name, a, b, r, q, exp[63:32], exp[31:0]);
        end
        vectors++;
        if (lat !== 34 || wide !== 1'b0 || dz !== 1'b0 || bcyc !== 34) begin
            errors++;
            $display("FAIL %s timing: lat=%0d wide=%b dz=%b busy=%0d want 34/0/0/34", name, lat, wide, dz, bcyc);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({hi, lo, busy, done, div_zero} !== 67'd0) begin
            errors++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b want all 0", hi, lo, busy, done, div_zero);
        end
        reset = 1'b0;
    endtask

    task automatic test_signs;
        check_div("pos_pos", 32'd100, 32'd7, 0);
        check_div("neg_pos", 32'hFFFFFF9C, 32'd7, 0);
        check_div("pos_neg", 32'd100, 32'hFFFFFFF9, 0);
        check_div("neg_neg", 32'hFFFFFF9C, 32'hFFFFFFF9, 0);
        check_div("small", 32'd5, 32'd9, 0);
        check_div("min_m1", 32'h80000000, 32'hFFFFFFFF, 0);
        check_div("min_min", 32'h80000000, 32'h80000000, 0);
        check_div("max_min", 32'h7FFFFFFF, 32'h80000000, 0);
    endtask

    task automatic test_div_zero;
        logic [31:0] q, r;
        logic        dz, wide;
        int          lat, bcyc;
        check_div("pre_zero", 32'd100, 32'd7, 0);
        do_div(32'd12345, 32'd0, 0, q, r, dz, lat, bcyc, wide);
        vectors++;
        if (r !== 32'd2 || q !== 32'd14) begin
            errors++;
            $display("FAIL div_zero hold: hi=%h lo=%h want hi=2 lo=e", r, q);
        end
        vectors++;
        if (lat !== 1 || dz !== 1'b1 || wide !== 1'b0 || bcyc !== 1) begin
            errors++;
            $display("FAIL div_zero timing: lat=%0d dz=%b wide=%b busy=%0d want 1/1/0/1", lat, dz, wide, bcyc);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 2 == 0) b = 32'($urandom_range(1, 1000)) * (($urandom % 2) ? 32'hFFFFFFFF : 32'd1);
            if (i % 3 == 0) a = 32'($urandom_range(0, 100000)) * (($urandom % 2) ? 32'hFFFFFFFF : 32'd1);
            if (b == 32'd0) b = 32'd1;
            check_div("random", a, b, 0);
        end
    endtask

    task automatic test_restart_ignore;
        check_div("restart", 32'd1000, 32'd3, 5);
    endtask

    task automatic test_back_to_back;
        logic [31:0] q, r;
        logic [63:0] exp;
        int          lat;
        dividend = 32'd200;
        divisor  = 32'd9;
        start    = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; q = lo; r = hi; break; end
        end
        exp = model(32'd200, 32'd9);
        vectors++;
        if (lat !== 34 || {r, q} !== exp || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b first: lat=%0d hi=%h lo=%h busy=%b want 34 %h %h 0", lat, r, q, busy, exp[63:32], exp[31:0]);
        end
        dividend = 32'd1000;
        divisor  = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b accept: busy=%b want 1", busy);
        end
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin lat = n; q = lo; r = hi; break; end
        end
        exp = model(32'd1000, 32'd7);
        vectors++;
        if (lat !== 34 || {r, q} !== exp) begin
            errors++;
            $display("FAIL b2b second: lat=%0d hi=%h lo=%h want 34 %h %h", lat, r, q, exp[63:32], exp[31:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic seen;
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if ({hi, lo, busy, done, div_zero} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid clear: hi=%h lo=%h busy=%b done=%b want 0", hi, lo, busy, done);
        end
        seen = done;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            seen |= done;
        end
        vectors++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid pulse: done seen=%b want 0", seen);
        end
        check_div("after_reset", 32'd100, 32'd7, 0);
    endtask

    initial begin
        test_reset;
        test_signs;
        test_div_zero;
        test_random;
        test_restart_ignore;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
